therm_front: RTL and testbench

THERM_FRONT -- requirements
Module: therm_front

---
 rtl/adc_pkg.sv | 31 +++
 rtl/sync_chain.sv | 26 ++
 rtl/therm_front.sv | 67 ++++++
 tb/tb_therm_front.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared flash-ADC constants and thermometer-code helpers.
// THERM_BUBBLE_FIX_EN selects 3-input majority correction of the synchronized code.
package adc_pkg;

    localparam int ADC_BITS = 3;
    localparam int NCMP     = 7;
    localparam int THERM_W  = 8;
    localparam logic [NCMP-1:0] FULL_SCALE = 7'h7F;

    // A clean code 0..01..1 plus one is a power of two, so the AND is zero.
    function automatic logic is_bubble(input logic [NCMP-1:0] s);
        logic [NCMP-1:0] inc;
        inc = s + NCMP'(1);
        return |(inc & s);
    endfunction

    function automatic logic [NCMP-1:0] bubble_fix(input logic [NCMP-1:0] s);
        logic [NCMP-1:0] c;
`ifdef THERM_BUBBLE_FIX_EN
        logic [NCMP+1:0] e;
        // Pad with an implicit 1 below bit 0 and 0 above the top bit.
        e = {1'b0, s, 1'b1};
        for (int i = 0; i < NCMP; i++)
            c[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
`else
        c = s;
`endif
        return c;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer, one chain per bit, cleared by async reset.
module sync_chain #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++)
                ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/therm_front.sv
// Flash-ADC comparator front end: synchronize, sample every DIV cycles, bubble check,
// full-scale counter. THERM_BUBBLE_FIX_EN enables majority correction of the code.
module therm_front
    import adc_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DIV         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NCMP-1:0]    cmp_in,
    input  logic               ovr_clr,
    output logic [THERM_W-1:0] d_out,
    output logic               valid,
    output logic               bubble_err,
    output logic [7:0]         ovr_cnt
);

    logic [NCMP-1:0] s;
    logic [NCMP-1:0] c;
    logic [7:0]      div_cnt;
    logic            strobe;

    sync_chain #(.STAGES(SYNC_STAGES), .WIDTH(NCMP)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (s)
    );

    assign strobe = en && (div_cnt == 8'(DIV - 1));
    assign c      = bubble_fix(s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            div_cnt <= '0;
        else if (!en || strobe)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    // Bit 0 is tied high so the priority encoder never sees an all-zero code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out      <= THERM_W'(1);
            valid      <= 1'b0;
            bubble_err <= 1'b0;
        end else begin
            valid      <= strobe;
            bubble_err <= strobe && is_bubble(s);
            if (strobe)
                d_out <= {c, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_cnt <= '0;
        else if (ovr_clr)
            ovr_cnt <= '0;
        else if (strobe && c == FULL_SCALE && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 8'd1;
    end

endmodule

// File: tb/tb_therm_front.sv
// Scoreboard bench: DIV=4 and DIV=1 instances share stimulus; a sample-history model predicts outputs.
module tb_therm_front;

    localparam int SS = 2;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, ovr_clr = 1'b0;
    logic [6:0] cmp_in = '0;
    logic [7:0] d4, d1, o4, o1;
    logic       v4, v1, b4, b1;

    always #5 clk = ~clk;

    therm_front #(.SYNC_STAGES(SS), .DIV(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in), .ovr_clr(ovr_clr),
        .d_out(d4), .valid(v4), .bubble_err(b4), .ovr_cnt(o4));

    therm_front #(.SYNC_STAGES(SS), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .cmp_in(cmp_in), .ovr_clr(ovr_clr),
        .d_out(d1), .valid(v1), .bubble_err(b1), .ovr_cnt(o1));

    typedef struct {
        logic [7:0] d;
        logic       b;
        logic [7:0] o;
    } exp_t;

    exp_t       q4[$], q1[$];
    logic [6:0] hist[$];
    int         run;
    int         ovr[2];
    logic [7:0] last_d[2];
    logic       ev[2];
    int         tests = 0, fails = 0;

    function automatic logic [6:0] ref_code(input logic [6:0] s);
        logic [6:0] c;
`ifdef THERM_BUBBLE_FIX_EN
        for (int i = 0; i < 7; i++) begin
            int lo, hi, mid;
            lo  = (i == 0) ? 1 : int'(s[i-1]);
            hi  = (i == 6) ? 0 : int'(s[i+1]);
            mid = int'(s[i]);
            c[i] = (lo + mid + hi) >= 2;
        end
`else
        c = s;
`endif
        return c;
    endfunction

    function automatic logic ref_bubble(input logic [6:0] s);
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++)
                if (!s[i] && s[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        q4.delete();
        q1.delete();
        run = 0;
        for (int k = 0; k < 2; k++) begin
            ovr[k] = 0; last_d[k] = 8'h01; ev[k] = 1'b0;
        end
    endtask

    // Called just after each rising edge with the inputs the DUT sampled on it.
    task automatic model_edge();
        logic [6:0] s, c;
        if (rst) begin
            model_reset();
            return;
        end
        hist.push_back(cmp_in);
        if (hist.size() > 8) void'(hist.pop_front());
        s   = (hist.size() > SS) ? hist[hist.size() - 1 - SS] : 7'h00;
        run = en ? run + 1 : 0;
        c   = ref_code(s);
        for (int k = 0; k < 2; k++) begin
            int  dv;
            logic st;
            exp_t e;
            dv = (k == 0) ? 4 : 1;
            st = en && (run % dv == 0);
            if (ovr_clr) ovr[k] = 0;
            else if (st && c == 7'h7F && ovr[k] < 255) ovr[k]++;
            ev[k] = st;
            if (st) begin
                last_d[k] = {c, 1'b1};
                e.d = last_d[k]; e.b = ref_bubble(s); e.o = 8'(ovr[k]);
                if (k == 0) q4.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic cyc(input logic e, input logic [6:0] c, input logic clr);
        en = e; cmp_in = c; ovr_clr = clr;
        @(posedge clk);
        #2;
        model_edge();
    endtask

    task automatic mon(input int k, input logic v, input logic [7:0] d,
                       input logic b, input logic [7:0] o);
        exp_t e;
        string n;
        n = (k == 0) ? "div4" : "div1";
        check({n, "_valid"}, 32'(v), 32'(ev[k]));
        check({n, "_d_out"}, 32'(d), 32'(last_d[k]));
        check({n, "_ovr_cnt"}, 32'(o), 32'(ovr[k]));
        if (v) begin
            if ((k == 0 ? q4.size() : q1.size()) == 0) begin
                tests++; fails++;
                $display("FAIL %s_unexpected_valid actual=1 expected=empty_queue at %0t", n, $time);
            end else begin
                e = (k == 0) ? q4.pop_front() : q1.pop_front();
                check({n, "_sb_d_out"}, 32'(d), 32'(e.d));
                check({n, "_sb_bubble"}, 32'(b), 32'(e.b));
                check({n, "_sb_ovr"}, 32'(o), 32'(e.o));
            end
        end else begin
            check({n, "_bubble_no_valid"}, 32'(b), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, v4, d4, b4, o4);
            mon(1, v1, d1, b1, o1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d4"}, 32'(d4), 32'h01);
        check({tag, "_v4"}, 32'(v4), 32'd0);
        check({tag, "_b4"}, 32'(b4), 32'd0);
        check({tag, "_o4"}, 32'(o4), 32'd0);
        check({tag, "_d1"}, 32'(d1), 32'h01);
        check({tag, "_v1"}, 32'(v1), 32'd0);
        check({tag, "_o1"}, 32'(o1), 32'd0);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_reset_outputs("por");
        cyc(0, 7'h00, 0);
        cyc(0, 7'h00, 0);
        rst = 1'b0;

        // steady thermometer input, valid every 4th cycle on the DIV=4 unit
        repeat (16) cyc(1, 7'h0F, 0);
        // bubbled code
        repeat (12) cyc(1, 7'b0001011, 0);

        // enable dropped mid-period for 5 cycles
        for (int i = 0; i < 4 && (run % 4) != 2; i++) cyc(1, 7'h03, 0);
        repeat (5) cyc(0, 7'h3F, 0);
        repeat (10) cyc(1, 7'h3F, 0);

        // DIV=1 step from zero code to one comparator
        repeat (4) cyc(1, 7'h00, 0);
        repeat (4) cyc(1, 7'h01, 0);

        // saturation, then clear coinciding with a strobe
        repeat (1210) cyc(1, 7'h7F, 0);
        for (int i = 0; i < 4 && (run % 4) != 3; i++) cyc(1, 7'h7F, 0);
        cyc(1, 7'h7F, 1);
        repeat (21) cyc(1, 7'h7F, 0);

        // asynchronous reset mid-period, checked before any clock edge
        #1 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        cyc(1, 7'h7F, 0);
        rst = 1'b0;

        // randomized traffic
        repeat (600) begin
            logic [7:0] t;
            logic [6:0] c;
            int n;
            n = $urandom_range(0, 7);
            t = (8'd1 << n) - 8'd1;
            c = ($urandom % 2 == 0) ? t[6:0] : 7'($urandom);
            cyc(($urandom % 8) != 0, c, ($urandom % 50) == 0);
        end

        repeat (2) cyc(0, 7'h00, 0);
        @(negedge clk);
        #1;
        check("q4_drained", 32'(q4.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
